// File: rtl/sha256_compress_ctrl.sv
// SHA-256 compression sequencer: loads 16 words, runs 64 rounds at one per cycle, folds into H, presents digest.
// Build option SHA256_MULTIBLOCK_EN adds msg_last and chains H across the blocks of one message.
module sha256_compress_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ROUNDS     = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   word_in,
    input  logic                    word_valid,
    output logic                    word_ready,
`ifdef SHA256_MULTIBLOCK_EN
    input  logic                    msg_last,
`endif
    output logic [8*DATA_WIDTH-1:0] digest_out,
    output logic                    digest_valid,
    input  logic                    digest_ready,
    output logic                    busy,
    output logic [5:0]              round_idx
);
    typedef logic [31:0] word_t;
    typedef enum logic [2:0] {IDLE, LOAD, ROUND, UPDATE, DONE} state_t;

    localparam word_t IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("sha256_compress_ctrl: DATA_WIDTH must be 32");
    end

    rounds_legal: assert property (@(posedge clk) disable iff (rst) ROUNDS == 64);

    state_t     state;
    logic [3:0] cnt;
    word_t      w_buf [16];
    word_t      h_reg [8];
    word_t      wv    [8];   // working variables a..h
`ifdef SHA256_MULTIBLOCK_EN
    logic       last_blk;
`endif
    logic [3:0] t_lo, idx_m2, idx_m7, idx_m15;
    word_t      w_t, t1, t2;

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic word_t big_s0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction
    function automatic word_t big_s1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction
    function automatic word_t small_s0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic word_t small_s1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    assign digest_out = {h_reg[0], h_reg[1], h_reg[2], h_reg[3], h_reg[4], h_reg[5], h_reg[6], h_reg[7]};

    always_comb begin
        // NOTE: every signal here is assigned before any conditional use, so no latch can be inferred.
        t_lo    = round_idx[3:0];
        idx_m2  = t_lo - 4'd2;
        idx_m7  = t_lo - 4'd7;
        idx_m15 = t_lo - 4'd15;
        w_t     = w_buf[t_lo];
        // From t=16 the schedule is rebuilt in place; buffer[t mod 16] still holds W[t-16].
        if (round_idx >= 6'd16)
            w_t = small_s1(w_buf[idx_m2]) + w_buf[idx_m7] + small_s0(w_buf[idx_m15]) + w_buf[t_lo];
        t1 = wv[7] + big_s1(wv[4]) + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6])) + K[round_idx] + w_t;
        t2 = big_s0(wv[0]) + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
    end

    // NOTE: the schedule buffer has no reset; every entry is written in LOAD before a round reads it.
    always_ff @(posedge clk) begin
        if (state == LOAD && word_valid && word_ready)
            w_buf[cnt] <= word_in;
        else if (state == ROUND && round_idx >= 6'd16)
            w_buf[t_lo] <= w_t;
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            word_ready   <= 1'b0;
            digest_valid <= 1'b0;
            busy         <= 1'b0;
            round_idx    <= '0;
`ifdef SHA256_MULTIBLOCK_EN
            last_blk     <= 1'b1;
`endif
            for (int i = 0; i < 8; i++) begin
                h_reg[i] <= IV[i];
                wv[i]    <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (word_valid) begin
                        state      <= LOAD;
                        word_ready <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    if (word_valid && word_ready) begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            state      <= ROUND;
                            word_ready <= 1'b0;
                            round_idx  <= '0;
`ifdef SHA256_MULTIBLOCK_EN
                            last_blk   <= msg_last;
`endif
                            for (int i = 0; i < 8; i++) wv[i] <= h_reg[i];
                        end
                    end
                end
                ROUND: begin
                    wv[7] <= wv[6];
                    wv[6] <= wv[5];
                    wv[5] <= wv[4];
                    wv[4] <= wv[3] + t1;
                    wv[3] <= wv[2];
                    wv[2] <= wv[1];
                    wv[1] <= wv[0];
                    wv[0] <= t1 + t2;
                    round_idx <= round_idx + 6'd1;
                    if (round_idx == 6'(ROUNDS - 1)) begin
                        state     <= UPDATE;
                        round_idx <= '0;
                    end
                end
                UPDATE: begin
                    for (int i = 0; i < 8; i++) h_reg[i] <= h_reg[i] + wv[i];
`ifdef SHA256_MULTIBLOCK_EN
                    if (last_blk) begin
                        state        <= DONE;
                        digest_valid <= 1'b1;
                    end else begin
                        state      <= LOAD;
                        word_ready <= 1'b1;
                    end
`else
                    state        <= DONE;
                    digest_valid <= 1'b1;
`endif
                end
                DONE: begin
                    if (digest_valid && digest_ready) begin
                        state        <= IDLE;
                        digest_valid <= 1'b0;
                        busy         <= 1'b0;
                        for (int i = 0; i < 8; i++) h_reg[i] <= IV[i];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_compress_ctrl.sv
// Self-checking bench for sha256_compress_ctrl: cycle-level reference model plus directed FIPS 180-4 vectors.
// Define SHA256_MULTIBLOCK_EN for both bench and RTL to exercise the two-block message.
module tb_sha256_compress_ctrl;
    typedef logic [31:0] word_t;

    localparam logic [255:0] IV_CAT    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] TWO_DIG   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [31:0] KB [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  word_in;
    logic         word_valid;
    logic         word_ready;
    logic [255:0] digest_out;
    logic         digest_valid;
    logic         digest_ready;
    logic         busy;
    logic [5:0]   round_idx;
`ifdef SHA256_MULTIBLOCK_EN
    logic         msg_last;
    logic         drive_last = 1'b1;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    word_t abc_blk [16];
    word_t empty_blk [16];
    word_t two_b1 [16];
    word_t two_b2 [16];

    sha256_compress_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .word_in      (word_in),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
`ifdef SHA256_MULTIBLOCK_EN
        .msg_last     (msg_last),
`endif
        .digest_out   (digest_out),
        .digest_valid (digest_valid),
        .digest_ready (digest_ready),
        .busy         (busy),
        .round_idx    (round_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference SHA-256 block function ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x};
        return d[n +: 32];
    endfunction

    function automatic logic [255:0] sha_block(input logic [255:0] hin, input word_t blk [16]);
        word_t w [64];
        word_t h [8];
        word_t v [8];
        word_t s0, s1, t1, t2;
        for (int i = 0; i < 8; i++) h[i] = hin[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = blk[t];
            else begin
                s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
                s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
                w[t] = s1 + w[t-7] + s0 + w[t-16];
            end
        end
        v = h;
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KB[t] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) h[i] = h[i] + v[i];
        return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    endfunction

    // ---------------- cycle-level reference model ----------------
    // m_cyc counts edges since the 16th word was taken; -1 when no block is in flight.
    bit           m_busy = 0, m_ready = 0, m_dvalid = 0, m_last = 1;
    int           m_cyc = -1, m_n = 0;
    logic [255:0] m_h = IV_CAT;
    word_t        m_block [16];

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_busy = 0; m_ready = 0; m_dvalid = 0; m_cyc = -1; m_n = 0; m_h = IV_CAT;
            end else if (m_cyc >= 0) begin
                m_cyc++;
                if (m_cyc == 65) begin
                    m_cyc = -1;
                    m_h = sha_block(m_h, m_block);
                    if (m_last) m_dvalid = 1; else m_ready = 1;
                end
            end else if (m_dvalid) begin
                if (digest_ready) begin m_dvalid = 0; m_busy = 0; m_h = IV_CAT; end
            end else if (m_ready) begin
                if (word_valid) begin
                    m_block[m_n] = word_in;
                    m_n++;
                    if (m_n == 16) begin
                        m_n = 0; m_ready = 0; m_cyc = 0;
`ifdef SHA256_MULTIBLOCK_EN
                        m_last = msg_last;
`else
                        m_last = 1;
`endif
                    end
                end
            end else if (!m_busy && word_valid) begin
                m_busy = 1; m_ready = 1;
            end
        end
    end

    // Compare every cycle, on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                check("word_ready", word_ready, m_ready);
                check("busy", busy, m_busy);
                check("digest_valid", digest_valid, m_dvalid);
                check("round_idx", round_idx, (m_cyc >= 0 && m_cyc < 64) ? m_cyc[5:0] : 6'd0);
                if (m_dvalid) check("digest_out", digest_out, m_h);
            end
        end
    end

    // ---------------- stimulus helpers (drive on negedge) ----------------
    task automatic send_block(input word_t blk [16], input bit gaps);
        int i = 0;
        int guard = 0;
        while (i < 16 && guard < 1000) begin
            @(negedge clk);
            guard++;
`ifdef SHA256_MULTIBLOCK_EN
            msg_last = drive_last;
`endif
            if (gaps && $urandom_range(0, 2) == 0) begin
                word_valid = 1'b0;
            end else begin
                word_valid = 1'b1;
                word_in    = blk[i];
                if (word_ready) i++;
            end
        end
        if (i != 16) check("send_timeout", i, 16);
    endtask

    task automatic wait_digest(input bit junk, output int lat);
        lat = 0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            word_valid = junk;
            word_in    = junk ? $urandom : 32'h0;
            if (digest_valid) begin lat = c; break; end
        end
        if (lat == 0) check("digest_timeout", digest_valid, 1'b1);
    endtask

    task automatic accept_digest(output logic [255:0] d);
        word_valid   = 1'b0;
        digest_ready = 1'b1;
        d            = digest_out;
        @(negedge clk);
        digest_ready = 1'b0;
        check("idle_after_hs_busy", busy, 1'b0);
        check("idle_after_hs_valid", digest_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] d;
        int           lat;
        bit           found;

        abc_blk   = '{32'h61626380, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00000018};
        empty_blk = '{32'h80000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        two_b1    = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        two_b2    = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h000001c0};

        rst = 1'b1; word_valid = 1'b0; word_in = '0; digest_ready = 1'b0;
`ifdef SHA256_MULTIBLOCK_EN
        msg_last = 1'b1;
`endif

        // Pin the reference model to published vectors.
        check("model_abc", sha_block(IV_CAT, abc_blk), ABC_DIG);
        check("model_empty", sha_block(IV_CAT, empty_blk), EMPTY_DIG);
        check("model_two_block", sha_block(sha_block(IV_CAT, two_b1), two_b2), TWO_DIG);

        repeat (2) @(negedge clk);
        check("rst_word_ready", word_ready, 1'b0);
        check("rst_digest_valid", digest_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_round_idx", round_idx, 6'd0);
        check("rst_digest_out", digest_out, IV_CAT);
        rst = 1'b0;

        // "abc" with exact latency, then 20 cycles of digest backpressure.
        send_block(abc_blk, 1'b0);
        wait_digest(1'b0, lat);
        check("abc_latency", lat, 66);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("bp_digest_out", digest_out, ABC_DIG);
            check("bp_digest_valid", digest_valid, 1'b1);
            check("bp_word_ready", word_ready, 1'b0);
            check("bp_busy", busy, 1'b1);
        end
        accept_digest(d);
        check("abc_digest", d, ABC_DIG);

        // Empty message with random input gaps; digest_ready held high while no digest is valid.
        digest_ready = 1'b1;
        send_block(empty_blk, 1'b1);
        digest_ready = 1'b0;
        wait_digest(1'b0, lat);
        accept_digest(d);
        check("empty_digest", d, EMPTY_DIG);

        // Reset at round 30, then rerun "abc".
        send_block(abc_blk, 1'b0);
        found = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            word_valid = 1'b0;
            if (round_idx == 6'd30) begin found = 1; break; end
        end
        check("reach_round30", found, 1'b1);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_round_idx", round_idx, 6'd0);
        check("abort_digest_out", digest_out, IV_CAT);
        @(negedge clk);
        rst = 1'b0;
        send_block(abc_blk, 1'b0);
        wait_digest(1'b0, lat);
        accept_digest(d);
        check("abc_after_abort", d, ABC_DIG);

        // Junk words during ROUND and DONE are ignored.
        send_block(empty_blk, 1'b0);
        wait_digest(1'b1, lat);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            word_valid = 1'b1;
            word_in    = $urandom;
            check("done_word_ready", word_ready, 1'b0);
        end
        accept_digest(d);
        check("empty_with_junk", d, EMPTY_DIG);
        send_block(abc_blk, 1'b0);
        wait_digest(1'b0, lat);
        accept_digest(d);
        check("abc_after_junk", d, ABC_DIG);

`ifdef SHA256_MULTIBLOCK_EN
        // Two-block message chained through H.
        drive_last = 1'b0;
        send_block(two_b1, 1'b0);
        drive_last = 1'b1;
        send_block(two_b2, 1'b0);
        wait_digest(1'b0, lat);
        accept_digest(d);
        check("two_block_digest", d, TWO_DIG);
        send_block(abc_blk, 1'b0);
        wait_digest(1'b0, lat);
        accept_digest(d);
        check("abc_after_chain", d, ABC_DIG);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
